// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined WIDTH-bit ALU with valid/ready handshake, flags and carry chaining
module alu_pipe #(
  parameter int WIDTH      = 16,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             bad_op
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MIN = 4'b0010, OP_MAX = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100, OP_OR = 4'b0101, OP_XOR = 4'b0110, OP_XNOR = 4'b0111;
  localparam logic [3:0] OP_ADDC = 4'b1000, OP_SUBB = 4'b1001, OP_SHL = 4'b1010, OP_SHR = 4'b1011;
  logic             stall;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [3:0]       s1_sel;
  logic             cflag;
  logic [WIDTH:0]   sum, dif, shl, shr;
  logic             arith, cin, lt_ab, lt_ba;
  logic [WIDTH-1:0] r_y;
  logic             r_c, r_v, r_bad;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_sel <= sel;
      end
    end
  end
  // Only ADDC/SUBB (sel[3]) consume the carry register; ADD/SUB start a fresh chain.
  always_comb begin
    arith = (s1_sel == OP_ADD) | (s1_sel == OP_SUB) | (s1_sel == OP_ADDC) | (s1_sel == OP_SUBB);
    cin   = s1_sel[3] & cflag;
    sum   = {1'b0, s1_a} + {1'b0, s1_b} + (WIDTH+1)'(cin);
    dif   = {1'b0, s1_a} - {1'b0, s1_b} - (WIDTH+1)'(cin);
    shl   = {1'b0, s1_a} << s1_b[SW-1:0];
    shr   = {s1_a, 1'b0} >> s1_b[SW-1:0];
    lt_ab = SIGNED_CMP ? ($signed(s1_a) < $signed(s1_b)) : (s1_a < s1_b);
    lt_ba = SIGNED_CMP ? ($signed(s1_b) < $signed(s1_a)) : (s1_b < s1_a);
    r_y   = '0;
    r_c   = 1'b0;
    r_bad = 1'b0;
    case (s1_sel)
      OP_ADD, OP_ADDC: {r_c, r_y} = sum;
      OP_SUB, OP_SUBB: {r_c, r_y} = dif;
      OP_MIN:  r_y = lt_ba ? s1_b : s1_a;
      OP_MAX:  r_y = lt_ab ? s1_b : s1_a;
      OP_AND:  r_y = s1_a & s1_b;
      OP_OR:   r_y = s1_a | s1_b;
      OP_XOR:  r_y = s1_a ^ s1_b;
      OP_XNOR: r_y = ~(s1_a ^ s1_b);
      OP_SHL:  {r_c, r_y} = shl;
      OP_SHR:  {r_y, r_c} = shr;
      default: r_bad = 1'b1;
    endcase
    // sel[0] distinguishes subtract: overflow needs differing operand signs there, equal signs for add.
    r_v = arith & ((s1_a[WIDTH-1] ^ s1_b[WIDTH-1]) == s1_sel[0]) & (r_y[WIDTH-1] ^ s1_a[WIDTH-1]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      bad_op    <= 1'b0;
      cflag     <= 1'b0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y      <= r_y;
        cout   <= r_c;
        zero   <= r_y == '0;
        neg    <= r_y[WIDTH-1];
        ovf    <= r_v;
        bad_op <= r_bad;
        if (arith) cflag <= r_c;
      end
    end
  end
endmodule
